// File: rtl/c_bufe_bus_receiver_v4_0.sv
// Receiving end of a BUFE tristate bus: round-robin grant, OE drive,
// one-cycle bus sample with float/contention flags, then a turnaround.
module c_bufe_bus_receiver_v4_0 #(
  parameter int C_WIDTH   = 16,
  parameter int C_NUM_SRC = 4,
  parameter int C_SRC_W   = 2
) (
  input  logic                 CLK,
  input  logic                 ACLR_N,
  input  logic [C_NUM_SRC-1:0] REQ,
  input  logic [C_WIDTH-1:0]   BUS,
  output logic [C_NUM_SRC-1:0] OE,
  output logic [C_WIDTH-1:0]   Q,
  output logic                 Q_VALID,
  output logic [C_SRC_W-1:0]   Q_SRC,
  output logic                 FLOAT_ERR,
  output logic                 CONT_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [C_SRC_W-1:0]     r_ptr;
  logic [C_SRC_W-1:0]     r_grant;
  logic [C_NUM_SRC-1:0]   w_oe_nxt;
  logic                   w_cap;
  logic                   w_found;
  logic [C_SRC_W-1:0]     w_gidx;
  logic                   w_float;
  logic                   w_cont;
  logic [C_SRC_W-1:0]     w_ptr_nxt;

  // Lowest offset from the pointer wins; only a solid 1 counts as a request.
  function automatic logic [C_SRC_W:0] f_search(
    input logic [C_NUM_SRC-1:0] req,
    input logic [C_SRC_W-1:0]   ptr
  );
    logic [C_SRC_W:0] r;
    int               j;
    r = '0;
    for (int i = C_NUM_SRC - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= C_NUM_SRC) j = j - C_NUM_SRC;
      if (req[j[C_SRC_W-1:0]] === 1'b1) r = {1'b1, C_SRC_W'(j)};
    end
    return r;
  endfunction

  // A floating bit reads z: nothing drove it.
  function automatic logic f_any_z(input logic [C_WIDTH-1:0] v);
    logic r;
    r = 1'b0;
    for (int b = 0; b < C_WIDTH; b++)
      if ($isunknown(v[b]) && (v[b] === 1'bz)) r = 1'b1;
    return r;
  endfunction

  // A contended bit resolves to x: drivers disagreed.
  function automatic logic f_any_x(input logic [C_WIDTH-1:0] v);
    logic r;
    r = 1'b0;
    for (int b = 0; b < C_WIDTH; b++)
      if ($isunknown(v[b]) && (v[b] !== 1'bz)) r = 1'b1;
    return r;
  endfunction

  // Arbitration, bus integrity and pointer advance.
  always_comb begin
    {w_found, w_gidx} = f_search(REQ, r_ptr);
    w_float = f_any_z(BUS);
    w_cont  = f_any_x(BUS);
    if (r_grant == C_SRC_W'(C_NUM_SRC - 1)) w_ptr_nxt = '0;
    else w_ptr_nxt = r_grant + 1'b1;
  end

  // Next state and next OE / capture strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_oe_nxt    = '0;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt      = S_DRIVE;
          w_oe_nxt[w_gidx] = 1'b1;
        end
      end
      S_DRIVE: begin
        w_state_nxt = S_TURN;
        w_cap       = 1'b1;
      end
      S_TURN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, pointer and all registered outputs.
  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      OE        <= '0;
      Q         <= '0;
      Q_VALID   <= 1'b0;
      Q_SRC     <= '0;
      FLOAT_ERR <= 1'b0;
      CONT_ERR  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      OE        <= w_oe_nxt;
      Q_VALID   <= w_cap;
      FLOAT_ERR <= w_cap & w_float;
      CONT_ERR  <= w_cap & w_cont;
      if (r_state == S_IDLE && w_found) r_grant <= w_gidx;
      if (w_cap) begin
        Q     <= BUS;
        Q_SRC <= r_grant;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_c_bufe_bus_receiver_v4_0.sv
// Bench for c_bufe_bus_receiver_v4_0: modelled BUFE drivers on a
// resolved bus, directed transfers, queue-based response checking.
module tb_c_bufe_bus_receiver_v4_0;

  logic        CLK;
  logic        ACLR_N;
  logic [3:0]  REQ;
  logic [15:0] BUS;
  logic [3:0]  OE;
  logic [15:0] Q;
  logic        Q_VALID;
  logic [1:0]  Q_SRC;
  logic        FLOAT_ERR;
  logic        CONT_ERR;

  c_bufe_bus_receiver_v4_0 #(
    .C_WIDTH(16), .C_NUM_SRC(4), .C_SRC_W(2)
  ) dut (
    .CLK(CLK), .ACLR_N(ACLR_N), .REQ(REQ), .BUS(BUS),
    .OE(OE), .Q(Q), .Q_VALID(Q_VALID), .Q_SRC(Q_SRC),
    .FLOAT_ERR(FLOAT_ERR), .CONT_ERR(CONT_ERR)
  );

  typedef struct {
    logic [15:0] q;
    logic [1:0]  src;
    logic        fe;
    logic        ce;
  } exp_t;

  exp_t sb[$];

  logic [3:0][15:0] dv;
  logic [3:0]       f_off;
  logic [3:0]       f_on;
  logic [3:0]       prev_oe;
  logic [15:0]      last_q;
  logic [1:0]       last_src;
  logic             xprobe;
  bit               four;
  int               n_chk;
  int               n_fail;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] f_resolve(input logic [3:0] oe);
    logic [15:0] r;
    int          n;
    r = '0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if ((oe[i] && !f_off[i]) || f_on[i]) begin
        if (n == 0) r = dv[i];
        else
          for (int b = 0; b < 16; b++)
            if (r[b] !== dv[i][b]) r[b] = 1'bx;
        n++;
      end
    end
    if (n == 0) r = 16'hzzzz;
    return r;
  endfunction

  // Drivers respond one time unit after their enable changes.
  always @(OE or dv or f_off or f_on) begin
    #1;
    BUS = f_resolve(OE);
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic push(input logic [1:0] src, input bit fe, input bit ce);
    exp_t e;
    logic [3:0] oh;
    oh = '0;
    oh[src] = 1'b1;
    e.q   = f_resolve(oh);
    e.src = src;
    e.fe  = fe;
    e.ce  = ce;
    sb.push_back(e);
  endtask

  task automatic do_xfer(input logic [3:0] req);
    int k;
    REQ = req;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!Q_VALID && k < 10);
    chk("xfer_timeout", 32'(Q_VALID), 32'd1);
    REQ = '0;
    repeat (2) @(negedge CLK);
  endtask

  always @(negedge ACLR_N) begin
    last_q   = '0;
    last_src = '0;
  end

  // Monitor: protocol invariants every cycle, scoreboard on Q_VALID.
  always @(negedge CLK) begin
    exp_t e;
    chk("oe_multi_hot", 32'($countones(OE) > 1), 32'd0);
    chk("oe_no_gap", 32'((prev_oe != 0) && (OE != 0)), 32'd0);
    prev_oe = OE;
    if (Q_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_qvalid: got src %0d expected none", Q_SRC);
      end else begin
        e = sb.pop_front();
        chk("q", 32'(Q), 32'(e.q));
        chk("q_src", 32'(Q_SRC), 32'(e.src));
        chk("float_err", 32'(FLOAT_ERR), 32'(e.fe));
        chk("cont_err", 32'(CONT_ERR), 32'(e.ce));
      end
      last_q   = Q;
      last_src = Q_SRC;
    end else begin
      chk("flags_idle", 32'(FLOAT_ERR | CONT_ERR), 32'd0);
      chk("q_hold", 32'(Q), 32'(last_q));
      chk("q_src_hold", 32'(Q_SRC), 32'(last_src));
    end
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    prev_oe  = '0;
    last_q   = '0;
    last_src = '0;
    ACLR_N   = 1'b0;
    REQ      = '0;
    f_off    = '0;
    f_on     = '0;
    dv[0]    = 16'h1111;
    dv[1]    = 16'h2222;
    dv[2]    = 16'hA5C3;
    dv[3]    = 16'h4444;
    xprobe   = 1'bx;
    #1;
    four = $isunknown(xprobe);

    // Reset held, then idle with no requests.
    repeat (3) @(negedge CLK);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_src", 32'(Q_SRC), 32'd0);
    ACLR_N = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      chk("idle_oe", 32'(OE), 32'd0);
      chk("idle_qv", 32'(Q_VALID), 32'd0);
    end

    // Single request from source 2.
    push(2'd2, 1'b0, 1'b0);
    REQ = 4'b0100;
    @(negedge CLK);
    chk("single_oe_on", 32'(OE), 32'h4);
    @(negedge CLK);
    chk("single_oe_off", 32'(OE), 32'h0);
    chk("single_qv", 32'(Q_VALID), 32'd1);
    REQ = '0;
    repeat (3) @(negedge CLK);

    // Fresh pointer, then all requesting: 0,1,2,3,0.
    #2 ACLR_N = 1'b0;
    #2 ACLR_N = 1'b1;
    dv[0] = 16'h1111;
    dv[1] = 16'h2222;
    dv[2] = 16'h3333;
    dv[3] = 16'h4444;
    @(negedge CLK);
    push(2'd0, 1'b0, 1'b0);
    push(2'd1, 1'b0, 1'b0);
    push(2'd2, 1'b0, 1'b0);
    push(2'd3, 1'b0, 1'b0);
    push(2'd0, 1'b0, 1'b0);
    REQ = 4'b1111;
    repeat (13) @(negedge CLK);
    REQ = '0;
    repeat (4) @(negedge CLK);

    // Source 0 after wrap, its driver stuck off: bus floats.
    f_off[0] = 1'b1;
    @(negedge CLK);
    push(2'd0, four, 1'b0);
    do_xfer(4'b0001);
    f_off[0] = 1'b0;

    // Source 1 fights a second driver stuck on.
    dv[1]   = 16'h00FF;
    dv[3]   = 16'h0F0F;
    f_on[3] = 1'b1;
    @(negedge CLK);
    push(2'd1, 1'b0, four);
    do_xfer(4'b0010);
    f_on[3] = 1'b0;
    @(negedge CLK);

    // Reset during DRIVE for source 3.
    REQ = 4'b1000;
    @(negedge CLK);
    chk("mid_oe_on", 32'(OE), 32'h8);
    #2 ACLR_N = 1'b0;
    #1 chk("mid_oe_async", 32'(OE), 32'h0);
    REQ = 4'b1001;
    @(negedge CLK);
    chk("mid_qv", 32'(Q_VALID), 32'd0);
    push(2'd0, 1'b0, 1'b0);
    #2 ACLR_N = 1'b1;
    do_xfer(4'b1001);

    // Unknown request bit never grants.
    push((REQ[2] === 1'b1) ? 2'd2 : 2'd3, 1'b0, 1'b0);
    REQ = 4'b1x00;
    if (REQ[2] === 1'b1) sb[sb.size()-1].src = 2'd2;
    do_xfer(4'b1x00);

    repeat (5) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
